// File: rtl/floorshift_pkg.sv
// rtl/floorshift_pkg.sv - shared constants, state type and latency helper for the floorshift log2/exp2 pair
//
// Contents:
//   INT_BITS            width of the integer part of a floorshift log2 value
//   fs_state_t          conversion FSM states
//   floorshift_latency  fixed calc-to-valid latency for a given output width

package floorshift_pkg;

    localparam int INT_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RND,
        WAIT
    } fs_state_t;

    // Worst case is OUT_BITS-1 shift cycles plus the SHIFT exit and RND cycles;
    // the extra edge lets the WAIT state emit every result on the same schedule.
    function automatic int floorshift_latency(input int out_bits);
        return out_bits + 2;
    endfunction

endpackage

// File: rtl/floorshift_convround.sv
// rtl/floorshift_convround.sv - combinational round/saturate stage for floorshift conversions
//
// Ports:
//   mant     in   OUT_BITS+FRAC_BITS+1  fixed-point value, binary point FRAC_BITS from the LSB
//   int_sat  in   1                     integer part already known to overflow the output
//   out      out  OUT_BITS              rounded (or truncated) integer, all-ones when saturated
//   sat      out  1                     result saturated

module floorshift_convround #(
    parameter int    FRAC_BITS = 8,
    parameter int    OUT_BITS  = 20,
    parameter string ROUND     = "TRUE"
) (
    input  logic [OUT_BITS+FRAC_BITS:0] mant,
    input  logic                        int_sat,
    output logic [OUT_BITS-1:0]         out,
    output logic                        sat
);

    localparam bit                   DO_ROUND = (ROUND == "TRUE");
    localparam logic [FRAC_BITS-1:0] HALF     = {1'b1, {(FRAC_BITS-1){1'b0}}};

    logic [OUT_BITS:0]    q;
    logic [OUT_BITS:0]    qr;
    logic [FRAC_BITS-1:0] r;
    logic                 round_up;

    always_comb begin
        q        = mant[OUT_BITS+FRAC_BITS:FRAC_BITS];
        r        = mant[FRAC_BITS-1:0];
        // Round half to even so repeated log/antilog passes carry no bias.
        round_up = DO_ROUND && ((r > HALF) || ((r == HALF) && q[0]));
        qr       = q + {{OUT_BITS{1'b0}}, round_up};
        // q has one spare bit so a rounding carry past the output range is visible.
        if (int_sat || qr[OUT_BITS]) begin
            out = '1;
            sat = 1'b1;
        end else begin
            out = qr[OUT_BITS-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/floorshift_exp2.sv
// rtl/floorshift_exp2.sv - iterative shift-based antilog, 2^(I.F) ~= (1.F) << I, fixed latency
//
// Ports:
//   clk_i    in   1              clock
//   rst_i    in   1              synchronous active-high reset
//   in_i     in   FRAC_BITS+5    log2 value {int[4:0], frac[FRAC_BITS-1:0]}
//   calc_i   in   1              start pulse, in_i sampled on the same edge; restarts a busy conversion
//   out_o    out  OUT_BITS       linear result, held until the next result
//   sat_o    out  1              result saturated, held alongside out_o
//   busy_o   out  1              conversion in progress
//   valid_o  out  1              one-cycle pulse when out_o/sat_o update

module floorshift_exp2
    import floorshift_pkg::*;
#(
    parameter int    FRAC_BITS = 8,
    parameter int    OUT_BITS  = 20,
    parameter string ROUND     = "TRUE"
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [FRAC_BITS+INT_BITS-1:0] in_i,
    input  logic                          calc_i,
    output logic [OUT_BITS-1:0]           out_o,
    output logic                          sat_o,
    output logic                          busy_o,
    output logic                          valid_o
);

    localparam int IN_W    = FRAC_BITS + INT_BITS;
    localparam int MANT_W  = OUT_BITS + FRAC_BITS + 1;
    localparam int LATENCY = floorshift_latency(OUT_BITS);
    localparam int TMR_W   = $clog2(LATENCY + 1);

    localparam logic [INT_BITS-1:0] SAT_INT  = INT_BITS'(OUT_BITS);
    localparam logic [TMR_W-1:0]    TMR_LOAD = TMR_W'(LATENCY - 1);

    fs_state_t             state;
    logic [MANT_W-1:0]     mant;
    logic [INT_BITS-1:0]   shcnt;
    logic                  sat_pend;
    logic [TMR_W-1:0]      tmr;
    logic [OUT_BITS-1:0]   res;
    logic                  res_sat;

    logic [INT_BITS-1:0]   in_int;
    logic [FRAC_BITS-1:0]  in_frac;
    logic                  in_ovf;
    logic [OUT_BITS-1:0]   cr_out;
    logic                  cr_sat;

    assign in_int  = in_i[IN_W-1:FRAC_BITS];
    assign in_frac = in_i[FRAC_BITS-1:0];
    assign in_ovf  = (in_int >= SAT_INT);

    floorshift_convround #(
        .FRAC_BITS (FRAC_BITS),
        .OUT_BITS  (OUT_BITS),
        .ROUND     (ROUND)
    ) u_convround (
        .mant    (mant),
        .int_sat (sat_pend),
        .out     (cr_out),
        .sat     (cr_sat)
    );

    // The timer is loaded with LATENCY-1 on the calc edge and reaches zero on the
    // edge before the emit edge, so WAIT releases exactly LATENCY edges after calc
    // regardless of how many shift cycles the integer part needed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            mant     <= '0;
            shcnt    <= '0;
            sat_pend <= 1'b0;
            tmr      <= '0;
            res      <= '0;
            res_sat  <= 1'b0;
            out_o    <= '0;
            sat_o    <= 1'b0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (tmr != '0) begin
                tmr <= tmr - 1'b1;
            end

            if (calc_i) begin
                // A new calc always wins: any conversion in flight is dropped and
                // out_o keeps the last completed value.
                mant     <= {{(MANT_W-FRAC_BITS-1){1'b0}}, 1'b1, in_frac};
                shcnt    <= in_int;
                sat_pend <= in_ovf;
                tmr      <= TMR_LOAD;
                busy_o   <= 1'b1;
                state    <= in_ovf ? RND : SHIFT;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    SHIFT: begin
                        if (shcnt != '0) begin
                            mant  <= mant << 1;
                            shcnt <= shcnt - 1'b1;
                        end else begin
                            state <= RND;
                        end
                    end
                    RND: begin
                        res     <= cr_out;
                        res_sat <= cr_sat;
                        state   <= WAIT;
                    end
                    WAIT: begin
                        if (tmr == '0) begin
                            out_o   <= res;
                            sat_o   <= res_sat;
                            valid_o <= 1'b1;
                            busy_o  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_floorshift_exp2.sv
// tb/tb_floorshift_exp2.sv - self-checking bench for floorshift_exp2

module tb_floorshift_exp2;

    localparam int LAT = 22;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        calc  = 1'b0;
    logic [12:0] din   = '0;

    logic [19:0] out, out_t;
    logic        sat, busy, valid;
    logic        sat_t, busy_t, valid_t;

    always #5 clk = ~clk;

    floorshift_exp2 #(.FRAC_BITS(8), .OUT_BITS(20), .ROUND("TRUE")) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .in_i    (din),
        .calc_i  (calc),
        .out_o   (out),
        .sat_o   (sat),
        .busy_o  (busy),
        .valid_o (valid)
    );

    floorshift_exp2 #(.FRAC_BITS(8), .OUT_BITS(20), .ROUND("FALSE")) dut_t (
        .clk_i   (clk),
        .rst_i   (rst),
        .in_i    (din),
        .calc_i  (calc),
        .out_o   (out_t),
        .sat_o   (sat_t),
        .busy_o  (busy_t),
        .valid_o (valid_t)
    );

    int     compared   = 0;
    int     mismatched = 0;
    longint cyc        = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [19:0] out;
        logic        sat;
        longint      due;
    } exp_t;

    exp_t sb[$];

    // Scoreboard consumer: every valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_valid: got out=%h sat=%b, required no valid", out, sat);
            end else begin
                e = sb.pop_front();
                compared++;
                if (out !== e.out) begin
                    mismatched++;
                    $display("FAIL result_out: got %h, required %h", out, e.out);
                end
                compared++;
                if (sat !== e.sat) begin
                    mismatched++;
                    $display("FAIL result_sat: got %b, required %b", sat, e.sat);
                end
                compared++;
                if (cyc !== e.due) begin
                    mismatched++;
                    $display("FAIL latency: valid at cycle %0d, required %0d", cyc, e.due);
                end
            end
        end
    end

    task automatic start(input logic [4:0] i, input logic [7:0] f,
                         input logic [19:0] eo, input logic es);
        exp_t e;
        @(negedge clk);
        din   = {i, f};
        calc  = 1'b1;
        e.out = eo;
        e.sat = es;
        e.due = cyc + 1 + LAT;
        sb.push_back(e);
        @(negedge clk);
        calc = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_one(input logic [4:0] i, input logic [7:0] f,
                           input logic [19:0] eo, input logic es);
        exp_t e;
        bit   busy_ok = 1'b1;
        bit   seen    = 1'b0;
        @(negedge clk);
        din   = {i, f};
        calc  = 1'b1;
        e.out = eo;
        e.sat = es;
        e.due = cyc + 1 + LAT;
        sb.push_back(e);
        for (int n = 0; n < LAT + 5; n++) begin
            @(negedge clk);
            calc = 1'b0;
            if (valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        compared++;
        if (!busy_ok || !seen) begin
            mismatched++;
            $display("FAIL busy_window: busy_held=%b valid_seen=%b, required 1 and 1", busy_ok, seen);
        end
        drain(4);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        din  = 13'h1FFF;
        calc = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (out !== 20'h0) begin mismatched++; $display("FAIL reset_out: got %h, required 0", out); end
        compared++;
        if (sat !== 1'b0) begin mismatched++; $display("FAIL reset_sat: got %b, required 0", sat); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b, required 0", busy); end
        compared++;
        if (valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b, required 0", valid); end
        calc = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rounding();
        logic [4:0]  ti [6] = '{5'd3, 5'd0, 5'd2, 5'd2, 5'd0, 5'd0};
        logic [7:0]  tf [6] = '{8'h20, 8'h80, 8'h60, 8'hA0, 8'h40, 8'h00};
        logic [19:0] tr [6] = '{20'd9, 20'd2, 20'd6, 20'd6, 20'd1, 20'd1};
        logic [19:0] tt [6] = '{20'd9, 20'd1, 20'd5, 20'd6, 20'd1, 20'd1};
        for (int k = 0; k < 6; k++) begin
            run_one(ti[k], tf[k], tr[k], 1'b0);
            compared++;
            if (out_t !== tt[k]) begin
                mismatched++;
                $display("FAIL truncate_%0d: got %h, required %h", k, out_t, tt[k]);
            end
        end
    endtask

    task automatic test_saturation();
        run_one(5'd19, 8'hFF, 20'hFF800, 1'b0);
        run_one(5'd20, 8'h00, 20'hFFFFF, 1'b1);
        run_one(5'd31, 8'hFF, 20'hFFFFF, 1'b1);
    endtask

    task automatic test_restart();
        exp_t dropped;
        start(5'd4, 8'h00, 20'd16, 1'b0);
        repeat (3) @(negedge clk);
        dropped = sb.pop_back();
        compared++;
        if (out !== 20'hFFFFF || dropped.out !== 20'd16) begin
            mismatched++;
            $display("FAIL restart_hold: got %h, required fffff", out);
        end
        start(5'd1, 8'h80, 20'd3, 1'b0);
        drain(40);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   seen = 1'b0;
        start(5'd2, 8'h60, 20'd6, 1'b0);
        for (int n = 0; n < LAT + 5; n++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL b2b_first_valid: seen=%b, required 1", seen);
        end
        din   = {5'd0, 8'h80};
        calc  = 1'b1;
        e.out = 20'd2;
        e.sat = 1'b0;
        e.due = cyc + 1 + LAT;
        sb.push_back(e);
        @(negedge clk);
        calc = 1'b0;
        drain(40);
    endtask

    task automatic test_reset_mid();
        start(5'd5, 8'h00, 20'd32, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        compared++;
        if (out !== 20'h0) begin mismatched++; $display("FAIL midreset_out: got %h, required 0", out); end
        compared++;
        if (sat !== 1'b0) begin mismatched++; $display("FAIL midreset_sat: got %b, required 0", sat); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL midreset_busy: got %b, required 0", busy); end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        run_one(5'd0, 8'h00, 20'd1, 1'b0);
    endtask

    // Feed back the floorshift log2 encoding of integers; values below 512 have an
    // exact 8-bit fraction and must reproduce the integer, larger ones lose the
    // bits the fraction could not hold.
    task automatic test_sweep();
        int i, f, expv;
        for (int n = 1; n < 4096; n = (n < 511) ? n + 1 : n + 61) begin
            i = 0;
            while ((n >> (i + 1)) != 0) i++;
            if (i <= 8) begin
                f    = (n - (1 << i)) << (8 - i);
                expv = n;
            end else begin
                f    = (n - (1 << i)) >> (i - 8);
                expv = (1 << i) + (f << (i - 8));
            end
            start(5'(i), 8'(f), 20'(expv), 1'b0);
            drain(40);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
